mux_8to1_arb: RTL

MUX_8TO1_ARB -- requirements
Module: mux_8to1_arb

---
 rtl/mux_8to1_arb.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mux_8to1_arb.sv
// Eight-channel packet multiplexer into a single registered output beat.
// Round-robin arbitration by default; define MUX8_FIXED_PRIO_EN for lowest-index-wins.
module mux_8to1_arb #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] i_data0,
    input  logic [DW-1:0] i_data1,
    input  logic [DW-1:0] i_data2,
    input  logic [DW-1:0] i_data3,
    input  logic [DW-1:0] i_data4,
    input  logic [DW-1:0] i_data5,
    input  logic [DW-1:0] i_data6,
    input  logic [DW-1:0] i_data7,
    input  logic [7:0]    i_valid,
    input  logic [7:0]    i_last,
    output logic [7:0]    o_ready,
    output logic [DW-1:0] o_data,
    output logic [2:0]    o_sel,
    output logic          o_last,
    output logic          o_valid,
    input  logic          i_ready
);

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [2:0]    r_rr_ptr;
    logic [2:0]    w_rr_ptr_next;
    logic [2:0]    r_lock_ch;
    logic [2:0]    w_lock_ch_next;

    logic [DW-1:0] r_data;
    logic [2:0]    r_sel;
    logic          r_last;
    logic          r_valid;

    logic [DW-1:0] w_data [8];
    logic          w_free;
    logic          w_gnt_valid;
    logic [2:0]    w_gnt_idx;
    logic [2:0]    w_scan_base;
    logic [2:0]    w_scan_idx;
    logic          w_xfer;
    logic          w_xfer_last;
    logic [7:0]    w_ready;

    assign w_data[0] = i_data0;
    assign w_data[1] = i_data1;
    assign w_data[2] = i_data2;
    assign w_data[3] = i_data3;
    assign w_data[4] = i_data4;
    assign w_data[5] = i_data5;
    assign w_data[6] = i_data6;
    assign w_data[7] = i_data7;

    assign w_free = !r_valid || i_ready;

`ifdef MUX8_FIXED_PRIO_EN
    assign w_scan_base = 3'd0;
`else
    assign w_scan_base = r_rr_ptr;
`endif

    // Descending scan so the smallest offset from the base is the final winner.
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_idx   = 3'd0;
        w_scan_idx  = 3'd0;
        if (r_state == LOCK) begin
            w_gnt_valid = i_valid[r_lock_ch];
            w_gnt_idx   = r_lock_ch;
        end else begin
            for (int i = 7; i >= 0; i--) begin
                w_scan_idx = w_scan_base + 3'(i);
                if (i_valid[w_scan_idx]) begin
                    w_gnt_valid = 1'b1;
                    w_gnt_idx   = w_scan_idx;
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ARB;
            r_rr_ptr  <= 3'd0;
            r_lock_ch <= 3'd0;
        end else begin
            r_state   <= w_state_next;
            r_rr_ptr  <= w_rr_ptr_next;
            r_lock_ch <= w_lock_ch_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next   = r_state;
        w_rr_ptr_next  = r_rr_ptr;
        w_lock_ch_next = r_lock_ch;
        if (w_xfer) begin
            if (w_xfer_last) begin
                w_state_next  = ARB;
                w_rr_ptr_next = w_gnt_idx + 3'd1;
            end else if (r_state == ARB) begin
                w_state_next   = LOCK;
                w_lock_ch_next = w_gnt_idx;
            end
        end
    end

    // Output logic: a transfer needs a grantee, a free output slot and no reset.
    always_comb begin
        w_xfer      = w_gnt_valid && w_free && !rst;
        w_xfer_last = i_last[w_gnt_idx];
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_ready
        assign w_ready[gi] = w_xfer && (w_gnt_idx == 3'(gi));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= 3'd0;
            r_last  <= 1'b0;
        end else if (w_free) begin
            r_valid <= w_xfer;
            if (w_xfer) begin
                r_data <= w_data[w_gnt_idx];
                r_sel  <= w_gnt_idx;
                r_last <= w_xfer_last;
            end
        end
    end

    assign o_ready = w_ready;
    assign o_data  = r_data;
    assign o_sel   = r_sel;
    assign o_last  = r_last;
    assign o_valid = r_valid;

endmodule
